// File: rtl/ofifo_param.sv
// ofifo_param
// Output FIFO between the PE array's bottom-row partial sums and the
// write-back path. Each column lane is written independently because the
// columns arrive skewed in time. Rows are read out whole through one shared
// read pointer into a registered output word.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low; clears all control state and out
//   wr[COLS]     per-lane write enable
//   in           lane i data at [(i+1)*PSUM_BW-1 : i*PSUM_BW]
//   rd           row read request
//   flush        synchronous clear of pointers, counts, out_valid and err
//   out          registered row data, same lane packing as in
//   out_valid    one-cycle strobe: out holds a newly read row
//   rd_ready     every lane holds at least one entry
//   almost_full  some lane holds >= DEPTH-AF_MARGIN entries
//   rows_avail   minimum lane count, i.e. whole rows readable
//   err          sticky: write to a full lane, or read while not rd_ready
module ofifo_param #(
  parameter  int COLS      = 8,
  parameter  int PSUM_BW   = 16,
  parameter  int DEPTH     = 16,
  parameter  int AF_MARGIN = 2,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COLS-1:0]         wr,
  input  logic [COLS*PSUM_BW-1:0] in,
  input  logic                    rd,
  input  logic                    flush,
  output logic [COLS*PSUM_BW-1:0] out,
  output logic                    out_valid,
  output logic                    rd_ready,
  output logic                    almost_full,
  output logic [CW-1:0]           rows_avail,
  output logic                    err
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_MARGIN);

  logic signed [PSUM_BW-1:0] mem [COLS][DEPTH];
  logic [AW-1:0]             wp  [COLS];
  logic [CW-1:0]             cnt [COLS];
  logic [AW-1:0]             rp;

  logic [COLS-1:0]           wr_acc;
  logic [COLS-1:0]           wr_drop;
  logic                      rd_acc;

  logic [COLS*PSUM_BW-1:0]   row_p1;
  logic                      vld_p1;
  logic                      err_q;

  // Status flags look only at the registered counts, never at same-cycle
  // wr/rd, so they are safe to use as back-pressure without comb loops.
  always_comb begin
    rd_ready    = 1'b1;
    almost_full = 1'b0;
    rows_avail  = cnt[0];
    for (int i = 0; i < COLS; i++) begin
      if (cnt[i] == '0)        rd_ready    = 1'b0;
      if (cnt[i] >= AF_CNT)    almost_full = 1'b1;
      if (cnt[i] < rows_avail) rows_avail  = cnt[i];
    end
  end

  // A full lane still accepts a write when a row read frees a slot in the
  // same cycle. Flush overrides both directions.
  always_comb begin
    rd_acc  = rd & rd_ready & ~flush;
    wr_acc  = '0;
    wr_drop = '0;
    for (int i = 0; i < COLS; i++) begin
      wr_acc[i]  = wr[i] & ~flush & ((cnt[i] != FULL_CNT) | rd_acc);
      wr_drop[i] = wr[i] & ~flush & ~wr_acc[i];
    end
  end

  // Lane storage: written at wp, never cleared (flush only resets pointers).
  always_ff @(posedge clk) begin
    for (int i = 0; i < COLS; i++) begin
      if (wr_acc[i]) mem[i][wp[i]] <= in[i*PSUM_BW +: PSUM_BW];
    end
  end

  // Pointer, count and flag state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rp     <= '0;
      vld_p1 <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < COLS; i++) begin
        wp[i]  <= '0;
        cnt[i] <= '0;
      end
    end else if (flush) begin
      rp     <= '0;
      vld_p1 <= 1'b0;
      err_q  <= 1'b0;
      for (int i = 0; i < COLS; i++) begin
        wp[i]  <= '0;
        cnt[i] <= '0;
      end
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) rp <= rp + AW'(1);
      if ((rd & ~rd_ready) | (|wr_drop)) err_q <= 1'b1;
      for (int i = 0; i < COLS; i++) begin
        if (wr_acc[i]) wp[i] <= wp[i] + AW'(1);
        case ({wr_acc[i], rd_acc})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // ---- stage p1: registered row output (holds across flush) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_p1 <= '0;
    end else if (rd_acc) begin
      for (int i = 0; i < COLS; i++) begin
        row_p1[i*PSUM_BW +: PSUM_BW] <= mem[i][rp];
      end
    end
  end

  assign out       = row_p1;
  assign out_valid = vld_p1;
  assign err       = err_q;

endmodule

// File: tb/tb_ofifo_param.sv
// Testbench for ofifo_param: directed scenarios plus randomized traffic,
// checked cycle by cycle against a per-lane queue model.
module tb_ofifo_param;

  localparam int COLS      = 8;
  localparam int PSUM_BW   = 16;
  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 2;
  localparam int CW        = $clog2(DEPTH) + 1;
  localparam int W         = COLS * PSUM_BW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [COLS-1:0] wr = '0;
  logic [W-1:0]    din = '0;
  logic            rd = 1'b0;
  logic            flush = 1'b0;
  logic [W-1:0]    dout;
  logic            out_valid;
  logic            rd_ready;
  logic            almost_full;
  logic [CW-1:0]   rows_avail;
  logic            err;

  always #5 clk = ~clk;

  ofifo_param #(
    .COLS(COLS), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)
  ) dut (
    .clk(clk), .reset(reset), .wr(wr), .in(din), .rd(rd), .flush(flush),
    .out(dout), .out_valid(out_valid), .rd_ready(rd_ready),
    .almost_full(almost_full), .rows_avail(rows_avail), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: one queue per lane plus output/flag registers
  logic [PSUM_BW-1:0] q [COLS][$];
  logic [W-1:0]       m_out = '0;
  logic               m_valid = 1'b0;
  logic               m_err = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    for (int i = 0; i < COLS; i++) if (q[i].size() == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_af();
    for (int i = 0; i < COLS; i++) if (q[i].size() >= DEPTH - AF_MARGIN) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_min();
    int mn = DEPTH;
    for (int i = 0; i < COLS; i++) if (q[i].size() < mn) mn = q[i].size();
    return mn;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < COLS; i++) r[i*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
    return r;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < COLS; i++) q[i].delete();
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock: drive at negedge, check status flags, advance the model,
  // then check registered outputs just after the rising edge.
  task automatic step(input logic [COLS-1:0] w, input logic [W-1:0] d,
                      input logic r, input logic f);
    bit rdacc;
    @(negedge clk);
    wr = w; din = d; rd = r; flush = f;
    #1;
    check("rd_ready", W'(rd_ready), W'(m_ready()));
    check("almost_full", W'(almost_full), W'(m_af()));
    check("rows_avail", W'(rows_avail), W'(m_min()));
    if (f) begin
      m_clear();
    end else begin
      rdacc = r && m_ready();
      if (r && !rdacc) m_err = 1'b1;
      if (rdacc)
        for (int i = 0; i < COLS; i++) m_out[i*PSUM_BW +: PSUM_BW] = q[i].pop_front();
      for (int i = 0; i < COLS; i++) begin
        if (w[i]) begin
          if (q[i].size() < DEPTH) q[i].push_back(d[i*PSUM_BW +: PSUM_BW]);
          else m_err = 1'b1;
        end
      end
      m_valid = rdacc;
    end
    @(posedge clk);
    #1;
    check("out_valid", W'(out_valid), W'(m_valid));
    check("err", W'(err), W'(m_err));
    check("out", dout, m_out);
  endtask

  // Reset asserted between edges: outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    wr = '0; din = '0; rd = 1'b0; flush = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_out", dout, '0);
    check("rst_out_valid", W'(out_valid), '0);
    check("rst_err", W'(err), '0);
    check("rst_rd_ready", W'(rd_ready), '0);
    check("rst_almost_full", W'(almost_full), '0);
    check("rst_rows_avail", W'(rows_avail), '0);
    m_clear();
    m_out = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [COLS-1:0] w;
    logic [W-1:0]    d;
    bit              fillp;

    do_reset();
    // read right after reset is ignored and flags err
    step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b1);

    // skewed fill: lane i starts at cycle i, value = row*16 + i
    for (int c = 0; c < COLS + 3; c++) begin
      w = '0; d = '0;
      for (int i = 0; i < COLS; i++) begin
        if (c - i >= 0 && c - i < 4) begin
          w[i] = 1'b1;
          d[i*PSUM_BW +: PSUM_BW] = PSUM_BW'((c - i) * 16 + i);
        end
      end
      step(w, d, 1'b0, 1'b0);
    end
    for (int k = 0; k < 4; k++) step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    check("skew_last_row", dout, 128'h0037_0036_0035_0034_0033_0032_0031_0030);

    // overflow on lane 0
    for (int k = 0; k < DEPTH + 1; k++) step(8'h01, rand_row(), 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b0, 1'b1);

    // all lanes full, simultaneous read and write
    for (int k = 0; k < DEPTH; k++) step('1, rand_row(), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step('1, rand_row(), 1'b1, 1'b0);
    for (int k = 0; k < DEPTH; k++) step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b0, 1'b0);

    // wrap-around: three fill/drain rounds of 10 rows
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 10; k++) step('1, rand_row(), 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) step('0, '0, 1'b1, 1'b0);
    end

    // asynchronous reset mid-stream with 5 rows stored
    for (int k = 0; k < 5; k++) step('1, rand_row(), 1'b0, 1'b0);
    do_reset();
    step('0, '0, 1'b1, 1'b0);

    // flush together with rd and wr while 6 rows are stored and err is set
    for (int k = 0; k < 6; k++) step('1, rand_row(), 1'b0, 1'b0);
    step('1, rand_row(), 1'b1, 1'b1);
    step('0, '0, 1'b0, 1'b0);
    step('0, '0, 1'b1, 1'b0);

    // randomized traffic, alternating fill-biased and drain-biased phases
    for (int k = 0; k < 3000; k++) begin
      fillp = ((k / 150) % 2) == 0;
      w = ($urandom_range(0, 3) == 0) ? '0 : COLS'($urandom);
      if (fillp) w = w | COLS'($urandom);
      step(w, rand_row(),
           $urandom_range(0, 99) < (fillp ? 30 : 75),
           $urandom_range(0, 199) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ofifo_param.md
# ofifo_param

Parametrised output FIFO between the PE array's bottom-row partial-sum outputs and the SRAM/SFU write-back path. Each column is written independently, since columns arrive skewed in time, and rows are read out together as one full-width word. Compared with the fixed 64-deep output FIFO, it adds a configurable depth, an almost-full back-pressure flag, a rows-available count, a registered read-valid strobe, a synchronous flush, and a sticky overflow/underflow error flag.

## Interface
- COLS, 8, number of PE columns / FIFO lanes
- PSUM_BW, 16, bits per partial sum
- DEPTH, 16, entries per lane; power of two, >= 2
- AF_MARGIN, 2, almost_full asserts when any lane has >= DEPTH-AF_MARGIN entries; 0 < AF_MARGIN < DEPTH
- CW (derived), $clog2(DEPTH)+1, count width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; all state cleared while low
- wr  in  COLS  per-lane write enable
- in  in  COLS*PSUM_BW  lane i data at [(i+1)*PSUM_BW-1 : i*PSUM_BW]
- rd  in  1  row read request
- flush  in  1  synchronous clear of all lanes
- out  out  COLS*PSUM_BW  registered row data, same lane packing as in
- out_valid  out  1  high for one cycle when out holds a newly read row
- rd_ready  out  1  every lane non-empty
- almost_full  out  1  any lane count >= DEPTH-AF_MARGIN
- rows_avail  out  CW  minimum lane count, i.e. full rows readable
- err  out  1  sticky: write to full lane or read while not rd_ready

## Operation
- Per-lane storage: DEPTH x PSUM_BW array, write pointer wp[i], count cnt[i].
- A single read pointer rp is shared by all lanes, because rows are always read whole.
- Read accepted: rd_acc = rd & rd_ready.
- On rd_acc:
  - out <= mem[i][rp] for every lane
  - rp increments
  - every cnt[i] decrements
  - out_valid <= 1
- Without rd_acc: out holds, out_valid <= 0.
- Write accepted on lane i: wr_acc[i] = wr[i] & ((cnt[i] < DEPTH) | rd_acc).
  - Effect: mem[i][wp[i]] <= in lane i; wp[i] increments.
- Count update when a lane sees both a write and a read: cnt[i] unchanged.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. There is no special case at the wrap.
- Write to a full lane with no rd_acc: data dropped, wp/cnt unchanged, err <= 1.
- rd while rd_ready=0: ignored, out holds, out_valid <= 0, err <= 1.
- Flush (highest priority over rd/wr in the same cycle):
  - clears wp, rp, cnt, out_valid and err
  - out holds its last value
  - mem contents are not cleared
- rd_ready, almost_full and rows_avail are combinational from cnt. They never depend on same-cycle wr or rd.
- Arithmetic: cnt ranges 0..DEPTH and needs CW bits. rows_avail = min over i of cnt[i].

## Timing
- Reset low (asynchronous): out=0, out_valid=0, err=0, all pointers and counts=0, hence rd_ready=0, almost_full=0, rows_avail=0.
- Reset release is synchronous to clk: first accepted operation is at the first rising edge with reset high.
- Write-to-read: data written at edge N is counted at N. rd_ready can rise after edge N; a read can be accepted at edge N+1 at the earliest.
- Read latency: rd sampled at edge N gives out and out_valid at edge N, visible for cycle N..N+1.
- Back-to-back reads: one row per cycle sustained while rd_ready stays high. out_valid stays high continuously.
- Full throughput: simultaneous write and read on a full lane sustains one entry per cycle without loss.
- Flush: takes effect at the edge where it is sampled. rd_ready=0 in the following cycle.

## Test plan
- Reset/idle: assert reset low mid-stream with cnt=5 -> immediately all outputs 0, rows_avail=0; after release, rd is ignored and err=1.
- Skewed fill: write lane i starting at cycle i (COLS=8, 4 rows each, value = row*16+i) -> rd_ready rises only after lane 7's first write; then 4 reads give rows 0x00..0x07 through 0x30..0x37 with out_valid high 4 cycles; rows_avail goes 4,3,2,1,0.
- Full/overflow: DEPTH=16, fill lane 0 with 16 writes -> almost_full high from count 14; 17th write without rd -> dropped, err=1, cnt stays 16.
- Full with simultaneous rd+wr: all lanes full, assert rd and wr for 20 cycles -> no data lost, err stays 0, outputs in order, cnt=16 throughout.
- Wrap-around: 3 fill/drain cycles of 10 rows with DEPTH=16 -> pointers wrap; data matches a reference queue exactly.
- Flush mid-operation: 6 rows stored, flush together with rd and wr -> next cycle cnt=0, rd_ready=0, out_valid=0, err=0; the concurrent write is discarded.
